mem_data_access: RTL
====================

MEM_DATA_ACCESS -- requirements
Module: mem_data_access

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the number of 32-bit words in the internal data RAM.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port i_valid, input, 1, request present from the MEM stage.
REQ-005 SHALL have port o_ready, output, 1, the block can accept a request this cycle.
REQ-006 SHALL have ports i_mem_read and i_mem_write, inputs, 1 each, load and store qualifiers.
REQ-007 SHALL have port i_load_store_type, input, 3: [1:0] size (00 byte, 01 half, 11 word); [2] unsigned flag, ignored here.
REQ-008 SHALL have ports i_addr (input, 32, byte address) and i_wdata (input, 32, store data, right-justified).
REQ-009 SHALL have port o_rdata, output, 32: load data right-justified, upper bits zero, for the downstream load-extension stage.
REQ-010 SHALL have port o_rvalid, output, 1, a one-cycle pulse when o_rdata holds a new load result.
REQ-011 SHALL have port o_stall, output, 1, equal to i_valid AND NOT o_ready.

Function
REQ-012 SHALL implement a state machine with states IDLE, RD_WAIT and RD_DONE; o_ready SHALL be 1 only in IDLE.
REQ-013 SHALL treat a request as accepted on a rising edge where i_valid and o_ready are both 1.
REQ-014 SHALL compute the word index as i_addr[DEPTH_LOG2+1:2] and ignore higher address bits (wrap-around); the byte lane is a = i_addr[1:0].
REQ-015 SHALL, on an accepted store, write the RAM at the accept edge using byte enables and stay in IDLE: byte writes i_wdata[7:0] to lane a; half writes i_wdata[15:0] to lanes {a[1],0} and {a[1],1}; word writes all four lanes.
REQ-016 SHALL, on an accepted load, register the index, lane and size, then move IDLE->RD_WAIT (synchronous RAM read) -> RD_DONE -> IDLE.
REQ-017 SHALL, in RD_DONE, drive o_rvalid=1 with o_rdata = {24'b0, lane a} for byte, {16'b0, upper or lower half selected by a[1]} for half, and the full word for word; load latency is exactly 2 cycles from the accept edge.
REQ-018 SHALL hold o_rdata unchanged until the next load completes.
REQ-019 SHALL, when i_mem_read and i_mem_write are both 1, perform only the load and suppress the store.
REQ-020 SHALL accept a request with neither qualifier set as a no-op: no RAM access and no state change.
REQ-021 SHALL, without the macro in REQ-026, force misaligned addresses: half ignores a[0]; word ignores a[1:0].
REQ-022 SHALL make a store to the same word as a load in flight visible only to later loads; in practice this case cannot occur because o_ready=0 while a load is in flight.

Reset
REQ-023 SHALL, while i_rst_n=0, put the FSM in IDLE and drive o_rvalid=0, o_rdata=0 and o_ready=1 (o_stall follows REQ-011).
REQ-024 SHALL, when reset asserts during RD_WAIT or RD_DONE, drop the pending load with no o_rvalid pulse after reset.
REQ-025 SHALL leave RAM contents unchanged by reset; they are undefined at power-up.

Configuration
REQ-026 SHALL, when MEM_MISALIGN_TRAP_EN is defined, add output o_misaligned (1 bit) and mark as misaligned any half access with a[0]=1 and any word access with a[1:0]!=0.
REQ-027 SHALL, with MEM_MISALIGN_TRAP_EN defined, perform no RAM write for a misaligned store and pulse o_misaligned for the cycle after the accept edge.
REQ-028 SHALL, with MEM_MISALIGN_TRAP_EN defined, take a misaligned load through the normal FSM but in RD_DONE pulse o_misaligned instead of o_rvalid, leaving o_rdata unchanged.
REQ-029 SHALL, without MEM_MISALIGN_TRAP_EN, omit port o_misaligned and apply REQ-021.

Verification
REQ-030 Store word 0xDEADBEEF to addr 0x10, then load word from 0x10 -> o_rvalid exactly 2 cycles after load accept, o_rdata=0xDEADBEEF, o_stall=1 while i_valid held during RD_WAIT/RD_DONE.
REQ-031 Store byte 0xA5 to 0x13 over the word 0x11223344 at 0x10, then load word 0x10 -> 0xA5223344; load byte 0x13 -> 0x000000A5.
REQ-032 Store half 0x8001 to 0x22, then load half 0x22 -> 0x00008001; load half 0x20 -> the prior lower half unchanged.
REQ-033 With DEPTH_LOG2=8, store word 0x12345678 to 0x400, then load word 0x000 -> 0x12345678 (wrap-around).
REQ-034 Assert i_rst_n=0 in RD_WAIT of a load from 0x10, then release -> no o_rvalid, o_rdata=0, o_ready=1, and RAM word 0x10 still reads back its prior value.
REQ-035 With MEM_MISALIGN_TRAP_EN, store word to 0x11 -> o_misaligned pulses one cycle after accept and RAM is unchanged; load half from 0x13 -> o_misaligned in RD_DONE and o_rvalid=0.

Source files
------------

// File: rtl/mem_data_access.sv
// MEM-stage data RAM: byte/half/word stores at the accept edge, loads returned two cycles later.
// Optional misalignment trap is enabled by defining MEM_MISALIGN_TRAP_EN (adds o_misaligned).
module mem_data_access #(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_load_store_type,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        o_misaligned,
`endif
    output logic        o_stall
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RD_DONE = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    logic [1:0]            state_q, state_d;
    logic                  accept;
    logic                  is_load, is_store;
    logic                  do_load, do_store;
    logic                  ld_done;

    logic [DEPTH_LOG2-1:0] req_idx;
    logic [1:0]            req_lane;
    logic [1:0]            req_size;
    logic [3:0]            wr_be;
    logic [31:0]           wr_data;

    logic [DEPTH_LOG2-1:0] idx_q;
    logic [1:0]            lane_q;
    logic [1:0]            size_q;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           rword_q;
    logic [31:0]           ld_data;
    logic [31:0]           rdata_q;

    // Unsigned flag is consumed by the downstream extension stage; high address bits wrap.
    logic                  unused_bits;
    assign unused_bits = ^{i_load_store_type[2], i_addr[31:DEPTH_LOG2+2]};

    assign req_idx  = i_addr[DEPTH_LOG2+1:2];
    assign req_lane = i_addr[1:0];
    assign req_size = i_load_store_type[1:0];

    assign o_ready  = (state_q == IDLE);
    assign o_stall  = i_valid & ~o_ready;
    assign accept   = i_valid & o_ready;

    // A request carrying both qualifiers is treated purely as a load.
    assign is_load  = i_mem_read;
    assign is_store = i_mem_write & ~i_mem_read;
    assign do_load  = accept & is_load;

`ifdef MEM_MISALIGN_TRAP_EN
    logic req_mis;
    logic st_mis_q;
    logic ld_mis_q;

    always_comb begin
        case (req_size)
            SZ_BYTE: req_mis = 1'b0;
            SZ_HALF: req_mis = req_lane[0];
            default: req_mis = (req_lane != 2'b00);
        endcase
    end

    assign do_store = accept & is_store & ~req_mis;
    assign ld_done  = (state_q == RD_DONE) & ~ld_mis_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_mis_q <= 1'b0;
            ld_mis_q <= 1'b0;
        end else begin
            st_mis_q <= accept & is_store & req_mis;
            if (do_load) begin
                ld_mis_q <= req_mis;
            end
        end
    end

    assign o_misaligned = st_mis_q | ((state_q == RD_DONE) & ld_mis_q);
`else
    assign do_store = accept & is_store;
    assign ld_done  = (state_q == RD_DONE);
`endif

    assign o_rvalid = ld_done;

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    // Without the trap, half accesses drop a[0] and word accesses drop a[1:0].
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = i_wdata;
        case (req_size)
            SZ_BYTE: begin
                wr_be   = 4'b0001 << req_lane;
                wr_data = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                wr_be   = req_lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{i_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = i_wdata;
            end
        endcase
    end

    // RAM has no reset; the read port is registered to map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[req_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (state_q == RD_WAIT) begin
            rword_q <= mem[idx_q];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (do_load) state_d = RD_WAIT;
            RD_WAIT: state_d = RD_DONE;
            RD_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            size_q  <= 2'b00;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (do_load) begin
                idx_q  <= req_idx;
                lane_q <= req_lane;
                size_q <= req_size;
            end
            if (ld_done) begin
                rdata_q <= ld_data;
            end
        end
    end

    always_comb begin
        ld_data = rword_q;
        case (size_q)
            SZ_BYTE: begin
                case (lane_q)
                    2'd0:    ld_data = {24'h0, rword_q[7:0]};
                    2'd1:    ld_data = {24'h0, rword_q[15:8]};
                    2'd2:    ld_data = {24'h0, rword_q[23:16]};
                    default: ld_data = {24'h0, rword_q[31:24]};
                endcase
            end
            SZ_HALF: ld_data = lane_q[1] ? {16'h0, rword_q[31:16]} : {16'h0, rword_q[15:0]};
            default: ld_data = rword_q;
        endcase
    end

    // Formatted data is shown live in RD_DONE, then held in rdata_q until the next load.
    assign o_rdata = ld_done ? ld_data : rdata_q;

endmodule
